// File: rtl/fetch_pkg.sv
// Shared widths and the fetch buffer entry layout for the instruction fetch front end.
package fetch_pkg;

  localparam int unsigned ADDR_W  = 16;
  localparam int unsigned INSTR_W = 32;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_if.sv
// Fetch unit boundary: prom address/data, branch redirect and the decode handshake.
interface fetch_if #(
  parameter int unsigned ADDR_W  = fetch_pkg::ADDR_W,
  parameter int unsigned INSTR_W = fetch_pkg::INSTR_W
);

  logic               fetch_en;
  logic [ADDR_W-1:0]  prom_addr;
  logic [INSTR_W-1:0] prom_instruction;
  logic               branch_valid;
  logic [ADDR_W-1:0]  branch_target;
  logic               instr_valid;
  logic [INSTR_W-1:0] instr_data;
  logic [ADDR_W-1:0]  instr_pc;
  logic               instr_ready;

  modport master (
    input  fetch_en,
    output prom_addr,
    input  prom_instruction,
    input  branch_valid,
    input  branch_target,
    output instr_valid,
    output instr_data,
    output instr_pc,
    input  instr_ready
  );

  modport slave (
    output fetch_en,
    input  prom_addr,
    output prom_instruction,
    output branch_valid,
    output branch_target,
    input  instr_valid,
    input  instr_data,
    input  instr_pc,
    output instr_ready
  );

endinterface

// File: rtl/fetch_fifo.sv
// Synchronous fetch buffer of {pc, instr} entries; flush wins over push and pop.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  fetch_entry_t     wdata,
  output fetch_entry_t     rdata,
  output logic [CNT_W-1:0] count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_pop;

  assign do_pop = pop && (count != '0);
  assign rdata  = mem[rd_ptr];

  // Storage is cleared on reset so the head reads as zero until the first push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count <= count + CNT_W'(push) - CNT_W'(do_pop);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: PC, single in-flight prom read tracking, credit-based issue
// into a small buffer, and branch flush.
module fetch_unit #(
  parameter int unsigned      ADDR_W     = fetch_pkg::ADDR_W,
  parameter int unsigned      INSTR_W    = fetch_pkg::INSTR_W,
  parameter int unsigned      FIFO_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
  input logic     clk,
  input logic     rst_n,
  fetch_if.master bus
);

  import fetch_pkg::*;

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned CRD_W = CNT_W + 1;

  logic [ADDR_W-1:0]  pc;
  logic               inflight;
  logic [ADDR_W-1:0]  inflight_pc;
  logic [CNT_W-1:0]   count;
  logic [INSTR_W-1:0] prom_word;
  logic               issue;
  logic               push;
  logic               pop;
  fetch_entry_t       entry_in;
  fetch_entry_t       head;

  assign prom_word = bus.prom_instruction;

  // Credit rule: buffered plus outstanding must leave room for the new request.
  assign issue = bus.fetch_en && !bus.branch_valid &&
                 ((CRD_W'(count) + CRD_W'(inflight)) < CRD_W'(FIFO_DEPTH));
  assign push  = inflight && !bus.branch_valid;
  assign pop   = bus.instr_valid && bus.instr_ready;

  assign entry_in.pc    = inflight_pc;
  assign entry_in.instr = prom_word;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else if (bus.branch_valid) begin
      pc       <= bus.branch_target;
      inflight <= 1'b0;
    end else if (issue) begin
      pc          <= pc + ADDR_W'(1);
      inflight    <= 1'b1;
      inflight_pc <= pc;
    end else begin
      inflight <= 1'b0;
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (bus.branch_valid),
    .wdata (entry_in),
    .rdata (head),
    .count (count)
  );

  assign bus.prom_addr   = pc;
  assign bus.instr_valid = (count != '0);
  assign bus.instr_data  = head.instr;
  assign bus.instr_pc    = head.pc;

endmodule
